// File: rtl/sp_pkg.sv
// Shared types and constants for the signal-probability sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sp_pkg;

  // Sequencer states, in the order a normal lane passes through them
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } sp_state_e;

  // Default array geometry
  localparam int SP_WIDTH   = 32;
  localparam int SP_CNT_W   = 21;
  localparam int SP_N       = 21;
  localparam int SP_TIMEOUT = 64;

  // Result written for a lane whose low count is zero (probability saturates)
  localparam logic [SP_N-1:0] SP_SAT_ONES = '1;

  // Bit offset of lane 'lane' inside a flattened bus of 'cnt_w'-bit counts
  function automatic int lane_lsb(input int lane, input int cnt_w);
    return lane * cnt_w;
  endfunction

endpackage

// File: rtl/sp_lane_mux.sv
// Registered WIDTH:1 selection of one lane's high/low count pair.
// Latency: 1 cycle from lane_i to hi_o/lo_o.
// Backpressure: none; reloads every cycle from the (frozen) count buses.
module sp_lane_mux
  import sp_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int CNT_W = SP_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(WIDTH)-1:0] lane_i,
  input  logic [WIDTH*CNT_W-1:0]   hi_cnt_i,
  input  logic [WIDTH*CNT_W-1:0]   lo_cnt_i,
  output logic [CNT_W-1:0]         hi_o,
  output logic [CNT_W-1:0]         lo_o
);

  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] lo_q;

  // Capture the selected lane's pair; the caller drives its next lane index
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_cnt_i[lane_lsb(int'(lane_i), CNT_W) +: CNT_W];
      lo_q <= lo_cnt_i[lane_lsb(int'(lane_i), CNT_W) +: CNT_W];
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/sp_sweep_ctrl.sv
// Walks all lanes, feeds hi/lo counts to one shared divider, writes quotients to the sp bank.
// Latency: per lane 3+D (divided), 2 (zero divisor), 1 (masked), 3+TIMEOUT (timed out); done 1 cycle after last lane.
// Backpressure: none; divider is waited on for at most TIMEOUT cycles, abort returns to IDLE next cycle.
module sp_sweep_ctrl
  import sp_pkg::*;
#(
  parameter int WIDTH   = SP_WIDTH,
  parameter int CNT_W   = SP_CNT_W,
  parameter int N       = SP_N,
  parameter int TIMEOUT = SP_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         lane_mask,
  input  logic [WIDTH*CNT_W-1:0]   hi_cnt,
  input  logic [WIDTH*CNT_W-1:0]   lo_cnt,
  output logic                     cnt_freeze,
  output logic                     div_start,
  output logic [CNT_W-1:0]         div_a,
  output logic [CNT_W-1:0]         div_b,
  input  logic                     div_done,
  input  logic [N-1:0]             div_quot,
  output logic                     sp_we,
  output logic [$clog2(WIDTH)-1:0] sp_addr,
  output logic [N-1:0]             sp_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int LW = $clog2(WIDTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(WIDTH - 1);
  // Instance-width copy of the package saturation value
  localparam logic [N-1:0] SAT_ONES = {N{1'b1}};

  sp_state_e        state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [N-1:0]     result_q, result_d;
  logic [CNT_W-1:0] div_a_q, div_a_d;
  logic [CNT_W-1:0] div_b_q, div_b_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] hi_sel, lo_sel;

  // Mux is steered by the next lane so the pair is ready when SELECT sees that lane
  sp_lane_mux #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lane_mux (
    .clk      (clk),
    .rst      (rst),
    .lane_i   (lane_d),
    .hi_cnt_i (hi_cnt),
    .lo_cnt_i (lo_cnt),
    .hi_o     (hi_sel),
    .lo_o     (lo_sel)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      wait_q   <= '0;
      result_q <= '0;
      div_a_q  <= '0;
      div_b_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; abort overrides every other transition, err is left untouched by it
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    wait_d   = wait_q;
    result_d = result_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    err_d    = err_q;

    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SELECT;
            lane_d  = '0;
            err_d   = 1'b0;
          end
        end
        ST_SELECT: begin
          if (lane_mask[lane_q]) begin
            if (lane_q == LAST_LANE) state_d = ST_DONE;
            else                     lane_d  = lane_q + LW'(1);
          end else if (lo_sel == '0) begin
            result_d = SAT_ONES;
            state_d  = ST_WRITE;
          end else begin
            div_a_d = hi_sel;
            div_b_d = lo_sel;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_d  = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            result_d = div_quot;
            state_d  = ST_WRITE;
          end else if (wait_q == TW'(TIMEOUT - 1)) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = ST_WRITE;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
        ST_WRITE: begin
          if (lane_q == LAST_LANE) begin
            state_d = ST_DONE;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = ST_SELECT;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes decode from state; an abort cycle suppresses them
  assign busy       = (state_q != ST_IDLE);
  assign cnt_freeze = (state_q != ST_IDLE);
  assign div_start  = (state_q == ST_ISSUE) && !abort;
  assign sp_we      = (state_q == ST_WRITE) && !abort;
  assign done       = (state_q == ST_DONE)  && !abort;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign sp_addr    = lane_q;
  assign sp_data    = result_q;
  assign err        = err_q;

endmodule
